// File: rtl/conv2d_stream_pkg.sv
// Shared definitions for the streaming 3x3 convolver.
//   out_width() : result width needed to hold a 9-term sum of unsigned products
//   state_e     : frame controller states
//   NUM_TAPS    : kernel tap count (3x3)
package conv2d_stream_pkg;

  localparam int NUM_TAPS = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // A product needs pix_w+coef_w bits; summing 9 of them needs 4 more bits.
  function automatic int out_width(input int pix_w, input int coef_w);
    return pix_w + coef_w + 4;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Fixed-length delay line: data_o is the sample pushed DEPTH enables ago.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : shift strobe (one pixel accepted)
//   data_i        : sample entering the line
//   data_o        : sample leaving the line (valid before the shift)
module conv_line_buffer #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
    end else if (en_i) begin
      sr_q[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  assign data_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 3x3 valid-mode convolution over a raster-scanned IMG_H x IMG_W
// frame, with a kernel loadable while idle.
// Ports:
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   coef_we_i/addr_i/data_i     : kernel tap write (tap r*3+c -> window row r, col c)
//   in_valid_i/in_ready_o/in_data_i : pixel input stream
//   out_valid_o/out_ready_i/out_data_o/out_last_o : result stream, raster order
//   busy_o                      : a frame is in progress
//   frame_done_o                : pulse when the final result of a frame handshakes
module conv2d_stream
  import conv2d_stream_pkg::*;
#(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int PIX_W  = 4,
  parameter int COEF_W = 4,
  localparam int OUT_W = out_width(PIX_W, COEF_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              coef_we_i,
  input  logic [3:0]        coef_addr_i,
  input  logic [COEF_W-1:0] coef_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PIX_W-1:0]  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COEF_W-1:0] tap_q [NUM_TAPS];
  logic [PIX_W-1:0]  win_q [3][3];
  logic [PIX_W-1:0]  win_d [3][3];
  logic [PIX_W-1:0]  lb0_out, lb1_out;
  logic [OUT_W-1:0]  prod [NUM_TAPS];
  logic [OUT_W-1:0]  mac_sum;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic accept, col_last, row_last, load, out_hs;

  assign accept   = in_valid_i && in_ready_o;
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  // A pixel at row>=2, col>=2 is the bottom-right corner of a complete window.
  assign load     = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign out_hs   = out_valid_q && out_ready_i;

  assign in_ready_o  = (state_q != ST_FLUSH) && (!out_valid_q || out_ready_i);
  assign busy_o      = (state_q != ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

  // Two chained delay lines give the same column from the two previous rows.
  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (accept),
    .data_i (in_data_i),
    .data_o (lb0_out)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (accept),
    .data_i (lb0_out),
    .data_o (lb1_out)
  );

  // Window after shifting in the incoming column; the MAC works on this so the
  // result can be registered in the same cycle the completing pixel arrives.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb1_out;
    win_d[1][2] = lb0_out;
    win_d[2][2] = in_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= win_d[r][c];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_prod
      assign prod[gi] = OUT_W'(tap_q[gi]) * OUT_W'(win_d[gi / 3][gi % 3]);
    end
  endgenerate

  always_comb begin
    mac_sum = '0;
    for (int k = 0; k < NUM_TAPS; k++) mac_sum = mac_sum + prod[k];
  end

  // Kernel taps: writable only while idle, default to a box filter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_TAPS; k++) tap_q[k] <= COEF_W'(1);
    end else if (coef_we_i && (state_q == ST_IDLE)) begin
      for (int k = 0; k < NUM_TAPS; k++)
        if (coef_addr_i == 4'(k)) tap_q[k] <= coef_data_i;
    end
  end

  // Raster position of the next pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Output register; a load can only coincide with a handshake, never a stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mac_sum;
      out_last_d  = row_last && col_last;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_done_o = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (accept && row_last && col_last) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (out_hs && out_last_q) begin
          frame_done_o = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;

  localparam int OUT_W = 12;

  logic             clk;
  logic             rst_n;
  logic             coef_we;
  logic [3:0]       coef_addr;
  logic [3:0]       coef_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             frame_done;

  conv2d_stream #(.IMG_W(5), .IMG_H(5), .PIX_W(4), .COEF_W(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .coef_we_i    (coef_we),
    .coef_addr_i  (coef_addr),
    .coef_data_i  (coef_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int frame_tab [2][25] = '{
    '{5,3,2,1,4, 0,0,1,2,3, 0,1,1,2,3, 4,1,0,1,2, 3,1,0,4,1},
    '{15,15,15,15,15, 15,15,15,15,15, 15,15,15,15,15, 15,15,15,15,15, 15,15,15,15,15}
  };
  int tap_tab [3][9] = '{
    '{1,1,1,1,1,1,1,1,1},
    '{0,0,0,0,1,0,0,0,0},
    '{15,15,15,15,15,15,15,15,15}
  };
  int exp_tab [4][9] = '{
    '{13,13,19,8,9,15,11,11,14},
    '{0,1,2,1,1,2,1,0,1},
    '{2025,2025,2025,2025,2025,2025,2025,2025,2025},
    '{43,31,31,8,9,21,11,17,20}
  };

  typedef struct {
    string name;
    int    tsel;   // -1: keep taps as they are (reset box kernel)
    int    fsel;
    int    esel;
  } vec_t;
  vec_t vecs [3];

  // Result-stream monitor: one entry per handshake.
  int got_data [$];
  bit got_last [$];
  bit got_fd   [$];
  int fd_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_data.push_back(int'(out_data));
      got_last.push_back(out_last);
      got_fd.push_back(frame_done);
      $display("  result #%0d: out_data=%0d out_last=%0b frame_done=%0b",
               got_data.size() - 1, out_data, out_last, frame_done);
    end
    if (rst_n && frame_done) fd_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_fd.delete();
  endtask

  task automatic send_pixel(input int p);
    bit acc;
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'(p);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("in_ready");
  endtask

  task automatic send_frame(input int fsel);
    for (int i = 0; i < 25; i++) send_pixel(frame_tab[fsel][i]);
    in_valid = 1'b0;
  endtask

  task automatic load_taps(input int tsel);
    for (int k = 0; k < 9; k++) begin
      coef_we   = 1'b1;
      coef_addr = 4'(k);
      coef_data = 4'(tap_tab[tsel][k]);
      @(posedge clk);
      #1;
    end
    coef_we = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("busy drop");
  endtask

  task automatic check_results(input string name, input int esel);
    check($sformatf("%s count", name), got_data.size(), 9);
    for (int k = 0; k < 9; k++) begin
      if (k < got_data.size()) begin
        check($sformatf("%s data[%0d]", name, k), got_data[k], exp_tab[esel][k]);
        check($sformatf("%s last[%0d]", name, k), 32'(got_last[k]), 32'(k == 8));
        check($sformatf("%s frame_done[%0d]", name, k), 32'(got_fd[k]), 32'(k == 8));
      end
    end
  endtask

  initial begin
    int  fd0;
    bit  found;

    vecs[0] = '{name: "box_reset_taps", tsel: -1, fsel: 0, esel: 0};
    vecs[1] = '{name: "center_tap",     tsel:  1, fsel: 0, esel: 1};
    vecs[2] = '{name: "all15_max",      tsel:  2, fsel: 1, esel: 2};

    rst_n     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", 32'(out_data), 0);
    check("reset out_last", 32'(out_last), 0);
    check("reset busy", 32'(busy), 0);
    check("reset frame_done", 32'(frame_done), 0);
    check("reset in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven full frames with free-running output.
    for (int v = 0; v < 3; v++) begin
      $display("vector %s", vecs[v].name);
      clear_mon();
      fd0 = fd_cnt;
      if (vecs[v].tsel >= 0) load_taps(vecs[v].tsel);
      send_frame(vecs[v].fsel);
      wait_idle();
      check_results(vecs[v].name, vecs[v].esel);
      check({vecs[v].name, " frame_done pulses"}, 32'(fd_cnt - fd0), 1);
      check({vecs[v].name, " busy after"}, 32'(busy), 0);
    end

    // Backpressure: stall the first result for three cycles.
    $display("sequence backpressure");
    load_taps(0);
    clear_mon();
    fork
      send_frame(0);
      begin
        found = 1'b0;
        for (int t = 0; t < 400; t++) begin
          @(posedge clk);
          #1;
          if (out_valid) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          out_ready = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("stall%0d out_data", s), 32'(out_data), 13);
            check($sformatf("stall%0d out_valid", s), 32'(out_valid), 1);
            check($sformatf("stall%0d in_ready", s), 32'(in_ready), 0);
            @(posedge clk);
            #1;
          end
          out_ready = 1'b1;
        end else begin
          timeout_fail("first out_valid");
        end
      end
    join
    wait_idle();
    check_results("backpressure", 0);

    // Tap write while busy must be ignored.
    $display("sequence write_while_busy");
    clear_mon();
    fork
      send_frame(0);
      begin
        repeat (8) @(posedge clk);
        #0;
        check("busy at ignored write", 32'(busy), 1);
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 4'd7;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
      end
    join
    wait_idle();
    check_results("busy_write", 0);

    // Tap write in the same cycle as the first pixel is accepted.
    $display("sequence write_with_first_pixel");
    clear_mon();
    fork
      send_frame(0);
      begin
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 4'd7;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
      end
    join
    wait_idle();
    check_results("tap0_7", 3);

    // Reset mid-frame: everything returns to reset, taps back to box.
    $display("sequence reset_mid_frame");
    clear_mon();
    fd0 = fd_cnt;
    for (int i = 0; i < 12; i++) send_pixel(frame_tab[0][i]);
    in_valid = 1'b0;
    check("busy before reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 0);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(0);
    wait_idle();
    check_results("after_reset", 0);
    check("after_reset frame_done pulses", 32'(fd_cnt - fd0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2d_stream.md
Name: conv2d_stream

Overview:
Streaming 3x3 valid-mode 2D convolution over a raster-scanned IMG_H x IMG_W frame with a runtime-loadable kernel. It replaces the flat-bus, fixed-size, fixed-kernel convolver with a generalised block. Pixels arrive one per handshake, and two line buffers plus a 3x3 window register build each window. Results leave in raster order on a valid/ready stream with backpressure, feeding pooling/accumulation stages downstream.

Parameters:
IMG_W, 5, frame width in pixels (>=3)
IMG_H, 5, frame height in rows (>=3)
PIX_W, 4, unsigned pixel width
COEF_W, 4, unsigned coefficient width
OUT_W, PIX_W+COEF_W+4, result width (localparam; 9 products never overflow)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
coef_we  in  1  kernel tap write strobe
coef_addr  in  4  tap index 0..8, raster order; tap r*3+c weights window row r, column c (no flip)
coef_data  in  COEF_W  tap value
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid&in_ready
in_data  in  PIX_W  pixel, raster order, row 0 first
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_data  out  OUT_W  window sum
out_last  out  1  high with final result of the frame
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse when final result handshakes

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, frame_done=0, busy=0, state=IDLE, row/col counters=0, all taps=1 (box sum), line buffers/window=0. in_ready=1 after reset.
- FSM: IDLE -> RUN on first accepted pixel. RUN -> FLUSH on acceptance of pixel (IMG_H-1, IMG_W-1). FLUSH -> IDLE when the out_last result handshakes; frame_done pulses in that cycle.
- in_ready = (state != FLUSH) && (!out_valid || out_ready). Stall is lossless; no skid buffer.
- Counters: col increments on each accepted pixel and wraps at IMG_W-1 to 0, which increments row. Row wraps to 0 at frame end.
- Pixel at (row, col) with row>=2 and col>=2 completes the window whose origin is (row-2, col-2). Its result is registered and out_valid is asserted the next cycle (latency 1). Exactly (IMG_H-2)*(IMG_W-2) results are produced per frame.
- out_data/out_last hold while out_valid && !out_ready. out_valid drops after a handshake unless a new result loads in the same cycle.
- Arithmetic: unsigned products, summed at full OUT_W width with no truncation or saturation.
- Kernel writes take effect only when state==IDLE and are visible the next cycle. A write in the same cycle as the first pixel is accepted. Writes while busy are ignored. There is no readback.
- Back-to-back frames: after returning to IDLE, the next pixel starts a new frame. Line-buffer contents from the old frame are never used, because outputs require row>=2 of the new frame.
- Reset mid-operation: every register returns immediately to its reset value, including taps=1. A partial frame is discarded and no out_last or frame_done is issued.

Decomposition:
- Shared package: OUT_W derivation function, FSM state encoding (IDLE/RUN/FLUSH), tap count constant 9.
- One sub-module: conv_line_buffer (IMG_W-deep, PIX_W-wide shift delay line with enable), instantiated twice.
- Window, MAC, and FSM stay in the top.

Test Plan:
- Reset taps, out_ready=1, stream 5x5 frame rows {5,3,2,1,4},{0,0,1,2,3},{0,1,1,2,3},{4,1,0,1,2},{3,1,0,4,1} -> out_data 13,13,19,8,9,15,11,11,14; out_last with 14; frame_done the cycle 14 handshakes; busy low after.
- Load tap4=1, others 0, same frame -> 0,1,2,1,1,2,1,0,1.
- All pixels 15, all taps 15 -> nine results of 2025, no overflow at OUT_W=12.
- Box kernel; hold out_ready=0 for 3 cycles when first result appears -> out_data holds 13, in_ready=0 throughout, full sequence unchanged, no loss or duplicate.
- Write tap0=7 while busy mid-frame -> ignored, results still the box-sum set; after frame_done the write is accepted.
- Deassert rst_n after 12 pixels -> out_valid=0, busy=0 at once; after release a full frame yields 13,...,14 with taps back to 1.
